serial_subtractor_4_bit: RTL

Bit-serial subtractor: the inverse operation of the team's parallel 4-bit full adder. Computes Diff = A − B − Bin one bit per clock, LSB first, reusing a single one-bit full-adder cell (two's-complement: invert B, carry-in = ~Bin). Sits beside the parallel adder in the arithmetic block set and trades area for latency. Uses a Start/Busy/Done handshake.

---
 rtl/serial_subtractor_4_bit_pkg.sv | 14 +
 rtl/serial_subtractor_4_bit_full_adder_1_bit.sv | 13 +
 rtl/serial_subtractor_4_bit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_4_bit_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and default width.
package serial_subtractor_4_bit_pkg;

    // Default operand/result width.
    localparam int W_DEFAULT = 4;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : serial_subtractor_4_bit_pkg

// File: rtl/serial_subtractor_4_bit_full_adder_1_bit.sv
// One-bit full adder cell, shared by every bit position of the serial subtractor.
module full_adder_1_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule : full_adder_1_bit

// File: rtl/serial_subtractor_4_bit.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock, LSB first,
// computed as A + ~B + ~Bin through a single full-adder cell.
module serial_subtractor_4_bit
    import serial_subtractor_4_bit_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Bin,
    output logic         Busy,
    output logic         Done,
    output logic [W-1:0] Diff,
    output logic         Bout,
    output logic         Ovf,
    output logic         Zero
);

    localparam int               CNT_W    = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [W-1:0]     r_a_sr;
    logic [W-1:0]     r_b_sr;
    logic [W-1:0]     r_d_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_sum;
    logic             w_cout;
    logic [W-1:0]     w_d_next;

    // A request is only taken when no subtraction is in flight.
    assign w_accept = Start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_state == ST_SHIFT) && (r_cnt == CNT_LAST);
    assign w_d_next = {w_sum, r_d_sr[W-1:1]};

    full_adder_1_bit u_fa (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE waits, SHIFT runs W cycles, DONE allows back-to-back Start.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (Start) begin
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial shifting and result registration on the last bit.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_d_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_a_sr  <= A;
            r_b_sr  <= ~B;
            r_d_sr  <= '0;
            r_carry <= ~Bin;
            r_cnt   <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_a_sr  <= {1'b0, r_a_sr[W-1:1]};
            r_b_sr  <= {1'b0, r_b_sr[W-1:1]};
            r_d_sr  <= w_d_next;
            r_carry <= w_cout;
            if (w_last) begin
                // r_carry is the carry into the MSB at this point.
                r_cnt  <= '0;
                r_diff <= w_d_next;
                r_bout <= ~w_cout;
                r_ovf  <= r_carry ^ w_cout;
                r_zero <= (w_d_next == '0);
            end else begin
                r_cnt  <= r_cnt + CNT_ONE;
            end
        end
    end

    assign Busy = (r_state == ST_SHIFT);
    assign Done = (r_state == ST_DONE);
    assign Diff = r_diff;
    assign Bout = r_bout;
    assign Ovf  = r_ovf;
    assign Zero = r_zero;

endmodule : serial_subtractor_4_bit
